// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, latencies, FSM states.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// Pipeline-controller <-> MDU bundle. The controller is the master, the MDU the slave.
interface mdu_if;

    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    modport master (
        output start, op, a, b,
        input  busy, hi, lo, rdata
    );

    modport slave (
        input  start, op, a, b,
        output busy, hi, lo, rdata
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational mult/div datapath: produces {hi, lo} for the requested op
// and flags a zero divisor so the caller can keep the old HI/LO.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] res_o,
    output logic        div_zero_o
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_num;
    logic [31:0] div_den;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        is_div;
    logic        is_signed_div;

    // Operand conditioning: sign extension for MULT, magnitudes for signed divide.
    // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
    always_comb begin
        a_sx          = {{32{a_i[31]}}, a_i};
        b_sx          = {{32{b_i[31]}}, b_i};
        mag_a         = a_i[31] ? (32'd0 - a_i) : a_i;
        mag_b         = b_i[31] ? (32'd0 - b_i) : b_i;
        is_div        = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
        is_signed_div = (op_i == MDU_DIV);
        div_zero_o    = is_div && (b_i == 32'd0);
        div_num       = is_signed_div ? mag_a : a_i;
        // Guard the divider against a zero divisor; the result is discarded anyway.
        div_den       = (b_i == 32'd0) ? 32'd1 : (is_signed_div ? mag_b : b_i);
        quo           = div_num / div_den;
        rem           = div_num % div_den;
    end

    // Result selection per op.
    always_comb begin
        res_o = '0;
        case (op_i)
            MDU_MULT:  res_o = a_sx * b_sx;
            MDU_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
            MDU_DIV: begin
                res_o[31:0]  = (a_i[31] ^ b_i[31]) ? (32'd0 - quo) : quo;
                res_o[63:32] = a_i[31] ? (32'd0 - rem) : rem;
            end
            MDU_DIVU:  res_o = {rem, quo};
            default:   res_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/div with HI/LO, mthi/mtlo writes
// and combinational mfhi/mflo reads.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_q;
    logic [31:0]      pend_lo_q;

    logic [63:0]      arith_res;
    logic             div_zero;
    logic             is_mul;
    logic             is_div;
    logic [31:0]      pend_hi_d;
    logic [31:0]      pend_lo_d;
    logic [31:0]      rdata_d;

    mdu_arith u_arith (
        .op_i       (bus.op),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .res_o      (arith_res),
        .div_zero_o (div_zero)
    );

    // Launch decode and the value to hold until commit. HI/LO cannot change
    // while busy, so a zero divisor simply pends the current HI/LO.
    always_comb begin
        is_mul    = (bus.op == MDU_MULT) || (bus.op == MDU_MULTU);
        is_div    = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
        pend_hi_d = div_zero ? hi_q : arith_res[63:32];
        pend_lo_d = div_zero ? lo_q : arith_res[31:0];
    end

    // FSM, latency counter, pending result and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && (is_mul || is_div)) begin
                        pend_hi_q <= pend_hi_d;
                        pend_lo_q <= pend_lo_d;
                        cnt_q     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_q   <= RUN;
                    end else if (bus.op == MDU_MTHI) begin
                        hi_q <= bus.a;
                    end else if (bus.op == MDU_MTLO) begin
                        lo_q <= bus.a;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        hi_q    <= pend_hi_q;
                        lo_q    <= pend_lo_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // mfhi/mflo read port: committed values only.
    always_comb begin
        rdata_d = '0;
        if (bus.op == MDU_MFHI) begin
            rdata_d = hi_q;
        end else if (bus.op == MDU_MFLO) begin
            rdata_d = lo_q;
        end
    end

    // Output drive.
    always_comb begin
        bus.busy  = (state_q == RUN);
        bus.hi    = hi_q;
        bus.lo    = lo_q;
        bus.rdata = rdata_d;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed + randomized bench for mdu against a plain-arithmetic HI/LO model.
module tb_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_if bus ();

    mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: HI/LO after an op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [31:0] x,
                                              input logic [31:0] y, input logic [63:0] prior);
        longint          sx, sy, sq, sr, sp;
        longint unsigned ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            MDU_MULT:  begin sp = sx * sy; return sp; end
            MDU_MULTU: return ux * uy;
            MDU_DIV: begin
                if (y == 32'd0) return prior;
                sq = sx / sy;
                sr = sx % sy;
                return {sr[31:0], sq[31:0]};
            end
            MDU_DIVU: begin
                if (y == 32'd0) return prior;
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return prior;
        endcase
    endfunction

    // Count negedges on which busy is high, starting with the current one.
    task automatic wait_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag);
        logic [63:0] r;
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        wait_busy(n);
        check({tag, "_busy_cycles"}, 32'(n), (o <= MDU_MULTU) ? 32'd5 : 32'd10);
        r = ref_model(o, x, y, {exp_hi, exp_lo});
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] x, input string tag);
        @(negedge clk);
        bus.op = o; bus.a = x;
        @(negedge clk);
        bus.op = MDU_NONE;
        if (o == MDU_MTHI) exp_hi = x; else exp_lo = x;
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
    endtask

    initial begin
        logic [63:0] r;
        logic [3:0]  o;
        logic [31:0] x, y;
        int n;

        reset = 1'b1;
        bus.start = 1'b0; bus.op = MDU_NONE; bus.a = '0; bus.b = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);

        // MULT -2 * 3
        run_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, "mult_neg");
        check("mult_neg_hi_const", bus.hi, 32'hFFFFFFFF);
        check("mult_neg_lo_const", bus.lo, 32'hFFFFFFFA);
        bus.op = MDU_MFLO; #1;
        check("rdata_mflo", bus.rdata, 32'hFFFFFFFA);
        bus.op = MDU_MFHI; #1;
        check("rdata_mfhi", bus.rdata, 32'hFFFFFFFF);
        bus.op = MDU_NONE; #1;
        check("rdata_none", bus.rdata, 32'd0);

        // DIVU 17/5, DIV -7/2, overflow case
        run_op(MDU_DIVU, 32'd17, 32'd5, "divu_17_5");
        check("divu_lo_const", bus.lo, 32'd3);
        check("divu_hi_const", bus.hi, 32'd2);
        run_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, "div_m7_2");
        check("div_lo_const", bus.lo, 32'hFFFFFFFD);
        check("div_hi_const", bus.hi, 32'hFFFFFFFF);
        run_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        check("div_ovf_lo_const", bus.lo, 32'h80000000);
        check("div_ovf_hi_const", bus.hi, 32'd0);

        // MTHI then divide by zero keeps HI/LO
        move_to(MDU_MTHI, 32'h12345678, "mthi");
        run_op(MDU_DIV, 32'd5, 32'd0, "div_zero");
        check("div_zero_hi_const", bus.hi, 32'h12345678);

        // MULTU, second start at busy cycle 3 ignored; reads show committed value
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULTU; bus.a = 32'hFFFFFFFF; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_MFHI;
        n = 1; #1;
        check("pend_rdata_mfhi", bus.rdata, exp_hi);
        @(negedge clk); n++;
        @(negedge clk); n++;
        bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        begin
            int rest;
            wait_busy(rest);
            check("ignore_start_busy_cycles", 32'(n + rest), 32'd5);
        end
        r = ref_model(MDU_MULTU, 32'hFFFFFFFF, 32'd2, {exp_hi, exp_lo});
        exp_hi = r[63:32]; exp_lo = r[31:0];
        check("ignore_start_hi", bus.hi, exp_hi);
        check("ignore_start_lo", bus.lo, exp_lo);
        @(negedge clk);
        check("ignore_start_idle", 32'(bus.busy), 32'd0);

        // Back-to-back: start held high is not taken at the commit edge
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_MULT; bus.a = 32'd7; bus.b = 32'hFFFFFFFD;
        @(negedge clk);
        bus.op = MDU_DIVU; bus.a = 32'd1000; bus.b = 32'd33;
        wait_busy(n);
        check("b2b_first_cycles", 32'(n), 32'd5);
        r = ref_model(MDU_MULT, 32'd7, 32'hFFFFFFFD, {exp_hi, exp_lo});
        exp_hi = r[63:32]; exp_lo = r[31:0];
        check("b2b_first_lo", bus.lo, exp_lo);
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        wait_busy(n);
        check("b2b_second_cycles", 32'(n), 32'd10);
        r = ref_model(MDU_DIVU, 32'd1000, 32'd33, {exp_hi, exp_lo});
        exp_hi = r[63:32]; exp_lo = r[31:0];
        check("b2b_second_hi", bus.hi, exp_hi);
        check("b2b_second_lo", bus.lo, exp_lo);

        // Reset at busy cycle 4 of a DIV aborts it
        @(negedge clk);
        bus.start = 1'b1; bus.op = MDU_DIV; bus.a = 32'd99; bus.b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.op = MDU_NONE;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        repeat (12) @(negedge clk);
        check("abort_no_commit_hi", bus.hi, 32'd0);
        check("abort_no_commit_lo", bus.lo, 32'd0);

        // MULT min*min then MTLO
        run_op(MDU_MULT, 32'h80000000, 32'h80000000, "mult_min");
        check("mult_min_hi_const", bus.hi, 32'h40000000);
        check("mult_min_lo_const", bus.lo, 32'd0);
        move_to(MDU_MTLO, 32'd1, "mtlo");
        check("mtlo_hi_const", bus.hi, 32'h40000000);

        // Randomized ops against the model
        for (int i = 0; i < 20; i++) begin
            o = 4'($urandom_range(1, 6));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 16));
                2: x = 32'($urandom_range(0, 100));
                default: ;
            endcase
            if (o >= MDU_MTHI) move_to(o, x, "rand_mt");
            else run_op(o, x, y, "rand_op");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage pipeline, sitting in the E stage beside the ALU. It is the responder on the pipeline controller's mult/div interface: it accepts `start` and a 4-bit operation code and computes HI/LO over a fixed multi-cycle latency. It reports `busy` back so the stall logic can hold later mult/div-class instructions in D. It also serves mthi/mtlo writes and mfhi/mflo reads.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu.
- `DIV_CYCLES`, 10: busy cycles for div/divu.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: launch request for mult/multu/div/divu; sampled only when `busy`=0.
- `op` input 4: operation code. Encodings: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO.
- `a` input 32: rs operand, already forwarded.
- `b` input 32: rt operand, already forwarded.
- `busy` output 1: operation in flight.
- `hi` output 32: architectural HI register.
- `lo` output 32: architectural LO register.
- `rdata` output 32: combinational read result. Equals `hi` when `op`=MFHI, `lo` when `op`=MFLO, otherwise 0.

## Operation
- State: IDLE and RUN. Registers: `cnt`, `hi`, `lo`, `pend_hi`, `pend_lo`.
- IDLE + `start`=1 + `op` in {1..4}:
  - capture the result into `pend_hi`/`pend_lo`;
  - load `cnt` with `MULT_CYCLES` for ops 1–2 or `DIV_CYCLES` for ops 3–4;
  - move to RUN.
- IDLE + `start`=1 + any other `op`: ignored.
- RUN: `cnt` decrements every cycle. On the edge where `cnt` goes 1→0, commit `hi`<=`pend_hi` and `lo`<=`pend_lo`, then return to IDLE.
- `busy` = (state == RUN).
- MTHI/MTLO: when `busy`=0, write `a` to `hi`/`lo` at the next edge, with no busy period. While `busy`=1, the write is ignored; the controller is responsible for stalling it.
- `start` while `busy`=1: ignored. The in-flight operation completes unchanged.
- Arithmetic:
  - MULT: signed 32×32→64 product; HI = [63:32], LO = [31:0].
  - MULTU: the same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder, carrying the sign of the dividend. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divisor 0: the full busy period still runs, but HI and LO keep their prior values at commit.
- `reset`: state IDLE, `cnt`=0, `busy`=0, `hi`=0, `lo`=0, `pend_*`=0. Reset mid-RUN aborts the operation, and no commit occurs.

## Timing
- Launch: `start` is sampled at edge E0. `busy`=1 from E0 through edge E0+N, where N = `MULT_CYCLES` or `DIV_CYCLES`. That is exactly N cycles high.
- Commit: `hi`/`lo` take the new values at edge E0+N, the same edge at which `busy` falls.
- Back-to-back: a new `start` may be accepted at edge E0+N+1 at the earliest. It is not accepted at the commit edge.
- MTHI/MTLO: 1-cycle latency to `hi`/`lo`.
- `rdata`: 0-cycle combinational from `op`/`hi`/`lo`; it shows the committed value, never the pending one.
- Controller contract (not enforced here): stall D-stage mult/div-class instructions while `start`||`busy`.

## Structure
- Package `mdu_pkg`:
  - op encoding constants `MDU_NONE` … `MDU_MFLO`;
  - default latency constants;
  - state enum {IDLE, RUN}.
- Sub-module `mdu_arith`: purely combinational.
  - Inputs: `op`, `a`, `b`.
  - Outputs: 64-bit {hi, lo} result and a `div_zero` flag.
  - Signed/unsigned selection and divide-by-zero detection live here.
- `mdu`: holds the FSM, the counter, the pending registers and HI/LO.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 -> `busy` high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; `rdata` with op=MFLO is 0xFFFFFFFA.
- DIVU a=17, b=5 -> `busy` high 10 cycles; then lo=3, hi=2. Also DIV a=−7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MTHI a=0x12345678 while idle -> hi=0x12345678 one cycle later, `busy` stays 0. Then DIV a=5, b=0 -> 10 busy cycles, hi unchanged at 0x12345678.
- MULTU start, then `start`=1 with op=DIV at busy cycle 3 -> second request ignored; `busy` falls after 5 cycles with the MULTU result only.
- DIV start, `reset` asserted at busy cycle 4 -> next cycle `busy`=0, hi=lo=0, and no later commit.
- MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0. Immediately afterwards MTLO a=1 -> lo=1, hi unchanged.
